// File: rtl/pkt_switch_pkg.sv
// Shared switch-wide constants and types for the ingress datapath.
package pkt_switch_pkg;

    localparam int N_PORTS    = 4;
    localparam int IDX_WIDTH  = $clog2(N_PORTS);
    localparam int DATA_WIDTH = 8;

    typedef logic [IDX_WIDTH-1:0] port_idx_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO: zero-latency head read, push/pop same cycle allowed.
// Push when full and pop when empty are ignored; no backpressure beyond full/empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == PW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ingress_packet_buffer.sv
// Store-and-forward ingress buffer: a packet becomes visible the cycle after its last beat;
// input never stalls (overflowing/rejected packets are discarded), output holds on out_ready=0.
module ingress_packet_buffer
    import pkt_switch_pkg::is_pow2;
#(
    parameter int DATA_WIDTH = pkt_switch_pkg::DATA_WIDTH,
    parameter int DEPTH      = 64,
    parameter int MAX_PKTS   = 8,
    parameter int N_PORTS    = pkt_switch_pkg::N_PORTS,
    parameter int IDX_WIDTH  = pkt_switch_pkg::IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [IDX_WIDTH-1:0]  in_dst,
    input  logic                  in_drop,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [IDX_WIDTH-1:0]  out_dst,
    input  logic                  out_ready,
    output logic [15:0]           drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_PKTS) + 1;

    if (!is_pow2(DEPTH) || !is_pow2(MAX_PKTS) || ((1 << IDX_WIDTH) < N_PORTS)) begin : g_bad_cfg
        $error("ingress_packet_buffer: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} in_state_t;

    in_state_t             state;
    in_state_t             state_nxt;
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [DATA_WIDTH:0]   head;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         wr_ptr_nxt;
    logic [PW-1:0]         commit_ptr;
    logic [PW-1:0]         commit_ptr_nxt;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         used;
    logic                  data_full;
    logic [IDX_WIDTH-1:0]  dst_q;
    logic [IDX_WIDTH-1:0]  dst_nxt;
    logic                  accept;
    logic                  mem_we;
    logic                  drop_inc;
    logic                  xfer;
    logic                  desc_push;
    logic                  desc_pop;
    logic [IDX_WIDTH-1:0]  desc_dst;
    logic [IDX_WIDTH-1:0]  desc_head;
    logic                  desc_full;
    logic                  desc_empty;
    logic [CW-1:0]         desc_count;

    assign in_ready  = !reset;
    assign accept    = in_valid && in_ready;
    assign used      = wr_ptr - rd_ptr;
    assign data_full = (used == PW'(DEPTH));

    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        dst_nxt        = dst_q;
        mem_we         = 1'b0;
        desc_push      = 1'b0;
        desc_dst       = dst_q;
        drop_inc       = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!desc_full && !data_full) begin
                        dst_nxt = in_dst;
                        if (in_last && in_drop) begin
                            // single-beat reject: rolling back the write is the same as never writing
                            drop_inc = 1'b1;
                        end else begin
                            mem_we     = 1'b1;
                            wr_ptr_nxt = wr_ptr + PW'(1);
                            if (in_last) begin
                                commit_ptr_nxt = wr_ptr + PW'(1);
                                desc_push      = 1'b1;
                                desc_dst       = in_dst;
                            end else begin
                                state_nxt = RECV;
                            end
                        end
                    end else if (in_last) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end
                RECV: begin
                    if (data_full) begin
                        wr_ptr_nxt = commit_ptr;
                        if (in_last) begin
                            drop_inc  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DISCARD;
                        end
                    end else if (in_last && in_drop) begin
                        wr_ptr_nxt = commit_ptr;
                        drop_inc   = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        if (in_last) begin
                            commit_ptr_nxt = wr_ptr + PW'(1);
                            desc_push      = 1'b1;
                            state_nxt      = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (in_last) begin
                        wr_ptr_nxt = commit_ptr;
                        drop_inc   = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            dst_q      <= '0;
            drop_count <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            dst_q      <= dst_nxt;
            if (xfer) rd_ptr <= rd_ptr + PW'(1);
            if (drop_inc && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
    end

    // Output fields are forced to zero when nothing is committed so stale memory never leaks out.
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = (desc_count != '0);
    assign out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;
    assign out_last  = out_valid && head[DATA_WIDTH];
    assign out_dst   = out_valid ? desc_head : '0;
    assign xfer      = out_valid && out_ready;
    assign desc_pop  = xfer && out_last && !desc_empty;

    sync_fifo #(
        .WIDTH (IDX_WIDTH),
        .DEPTH (MAX_PKTS)
    ) u_desc_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (desc_push),
        .push_data (desc_dst),
        .pop       (desc_pop),
        .pop_data  (desc_head),
        .full      (desc_full),
        .empty     (desc_empty),
        .count     (desc_count)
    );

endmodule

// File: tb/tb_ingress_packet_buffer.sv
// Bench for ingress_packet_buffer: directed table, corner sequences, random traffic vs queue model.
module tb_ingress_packet_buffer;
    import pkt_switch_pkg::*;

    localparam int DEPTH    = 64;
    localparam int MAX_PKTS = 8;

    logic                  clk;
    logic                  reset;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_last;
    port_idx_t             in_dst;
    logic                  in_drop;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    port_idx_t             out_dst;
    logic                  out_ready;
    logic [15:0]           drop_count;

    ingress_packet_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .MAX_PKTS   (MAX_PKTS),
        .N_PORTS    (N_PORTS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_dst     (in_dst),
        .in_drop    (in_drop),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_dst    (out_dst),
        .out_ready  (out_ready),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: committed beats as {last,data}, one dst per committed packet,
    // plus the beats of the packet currently arriving.
    logic [8:0]  m_beat[$];
    port_idx_t   m_dst[$];
    logic [8:0]  m_part[$];
    port_idx_t   m_pdst;
    bit          m_in_pkt = 0;
    bit          m_discarding = 0;
    logic [15:0] m_drops = 0;

    typedef struct {
        logic v; logic [7:0] d; logic l; port_idx_t dst; logic drp; logic ordy;
        logic ev; logic [7:0] ed; logic el; port_idx_t edst; logic [15:0] edrop;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_beat.delete(); m_dst.delete(); m_part.delete();
        m_in_pkt = 0; m_discarding = 0; m_drops = 0;
    endfunction

    // One clock cycle: drive, check DUT against model, advance model, wait for next negedge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic l, input port_idx_t dst,
                       input logic drp, input logic ordy, input logic rst);
        logic       ev;
        logic [8:0] popped;
        reset = rst; in_valid = v; in_data = d; in_last = l; in_dst = dst; in_drop = drp;
        out_ready = ordy;
        #1;
        ev = (m_dst.size() != 0);
        chk("in_ready", in_ready, !rst);
        chk("out_valid", out_valid, ev);
        if (ev) begin
            chk("out_data", out_data, m_beat[0][7:0]);
            chk("out_last", out_last, m_beat[0][8]);
            chk("out_dst", out_dst, m_dst[0]);
        end
        chk("drop_count", drop_count, m_drops);
        if (rst) begin
            model_reset();
        end else begin
            if (v) begin
                if (!m_in_pkt) begin
                    m_in_pkt = 1; m_pdst = dst;
                    m_discarding = (m_dst.size() == MAX_PKTS) || (m_beat.size() == DEPTH);
                end
                if (!m_discarding) begin
                    if (m_beat.size() + m_part.size() == DEPTH) begin
                        m_discarding = 1; m_part.delete();
                    end else begin
                        m_part.push_back({l, d});
                    end
                end
                if (l) begin
                    if (m_discarding || drp) begin
                        if (m_drops != 16'hFFFF) m_drops++;
                    end else begin
                        foreach (m_part[k]) m_beat.push_back(m_part[k]);
                        m_dst.push_back(m_pdst);
                    end
                    m_part.delete(); m_in_pkt = 0; m_discarding = 0;
                end
            end
            if (ev && ordy) begin
                popped = m_beat.pop_front();
                if (popped[8]) void'(m_dst.pop_front());
            end
        end
        @(negedge clk);
    endtask

    function automatic logic pick_rdy(input int mode);
        if (mode == 2) return ($urandom_range(0, 9) < 7);
        return (mode == 1);
    endfunction

    task automatic idle(input int n, input int mode);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 2'd0, 0, pick_rdy(mode), 0);
    endtask

    task automatic send_pkt(input int len, input logic [7:0] base, input port_idx_t dst,
                            input logic drp, input int mode);
        for (int i = 0; i < len; i++) begin
            if (mode == 2) idle($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0, mode);
            cyc(1, base + 8'(i), (i == len - 1), dst, drp && (i == len - 1), pick_rdy(mode), 0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && m_dst.size() != 0; i++) idle(1, 1);
        chk("drain_done", out_valid, 0);
    endtask

    task automatic row(input logic v, input logic [7:0] d, input logic l, input port_idx_t dst,
                       input logic drp, input logic ev, input logic [7:0] ed, input logic el,
                       input port_idx_t edst, input logic [15:0] edrop);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.dst = dst; r.drp = drp; r.ordy = 1'b1;
        r.ev = ev; r.ed = ed; r.el = el; r.edst = edst; r.edrop = edrop;
        tbl.push_back(r);
    endtask

    initial begin
        reset = 1; in_valid = 0; in_data = 0; in_last = 0; in_dst = 0; in_drop = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_dst", out_dst, 0);
        chk("rst_drop_count", drop_count, 0);

        // 3-beat, overlapped single beat (push/pop same cycle), rejected 4-beat, then 2-beat.
        row(1, 8'h11, 0, 2'd2, 0,   0, 8'h00, 0, 2'd0, 16'd0);
        row(1, 8'h22, 0, 2'd0, 0,   0, 8'h00, 0, 2'd0, 16'd0);
        row(1, 8'h33, 1, 2'd0, 0,   0, 8'h00, 0, 2'd0, 16'd0);
        row(0, 8'h00, 0, 2'd0, 0,   1, 8'h11, 0, 2'd2, 16'd0);
        row(0, 8'h00, 0, 2'd0, 0,   1, 8'h22, 0, 2'd2, 16'd0);
        row(1, 8'hA5, 1, 2'd1, 0,   1, 8'h33, 1, 2'd2, 16'd0);
        row(0, 8'h00, 0, 2'd0, 0,   1, 8'hA5, 1, 2'd1, 16'd0);
        row(0, 8'h00, 0, 2'd0, 0,   0, 8'h00, 0, 2'd0, 16'd0);
        row(1, 8'h60, 0, 2'd3, 0,   0, 8'h00, 0, 2'd0, 16'd0);
        row(1, 8'h61, 0, 2'd0, 0,   0, 8'h00, 0, 2'd0, 16'd0);
        row(1, 8'h62, 0, 2'd0, 0,   0, 8'h00, 0, 2'd0, 16'd0);
        row(1, 8'h63, 1, 2'd0, 1,   0, 8'h00, 0, 2'd0, 16'd0);
        row(0, 8'h00, 0, 2'd0, 0,   0, 8'h00, 0, 2'd0, 16'd1);
        row(1, 8'h5A, 0, 2'd3, 0,   0, 8'h00, 0, 2'd0, 16'd1);
        row(1, 8'h5B, 1, 2'd0, 0,   0, 8'h00, 0, 2'd0, 16'd1);
        row(0, 8'h00, 0, 2'd0, 0,   1, 8'h5A, 0, 2'd3, 16'd1);
        row(0, 8'h00, 0, 2'd0, 0,   1, 8'h5B, 1, 2'd3, 16'd1);
        row(0, 8'h00, 0, 2'd0, 0,   0, 8'h00, 0, 2'd0, 16'd1);
        foreach (tbl[i]) begin
            chk("tbl_valid", out_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk("tbl_data", out_data, tbl[i].ed);
                chk("tbl_last", out_last, tbl[i].el);
                chk("tbl_dst", out_dst, tbl[i].edst);
            end
            chk("tbl_drop", drop_count, tbl[i].edrop);
            cyc(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].dst, tbl[i].drp, tbl[i].ordy, 0);
        end

        // Overflow: 60 beats fit, the 10-beat follower runs out of space and is dropped.
        cyc(0, 8'h00, 0, 2'd0, 0, 0, 1);
        send_pkt(60, 8'h00, 2'd0, 0, 0);
        send_pkt(10, 8'h80, 2'd1, 0, 0);
        idle(1, 0);
        chk("ovf_buffered", out_valid, 1);
        chk("ovf_dst", out_dst, 0);
        chk("ovf_drop", drop_count, 1);
        drain();
        send_pkt(4, 8'hC0, 2'd3, 0, 1);
        chk("after_ovf_valid", out_valid, 1);
        chk("after_ovf_data", out_data, 8'hC0);
        drain();

        // Descriptor limit: nine one-beat packets, ninth dropped, order preserved.
        cyc(0, 8'h00, 0, 2'd0, 0, 0, 1);
        for (int i = 0; i < MAX_PKTS + 1; i++) send_pkt(1, 8'h40 + 8'(i), port_idx_t'(i), 0, 0);
        idle(1, 0);
        chk("desc_drop", drop_count, 1);
        for (int i = 0; i < MAX_PKTS; i++) begin
            chk("desc_order_data", out_data, 8'h40 + 8'(i));
            chk("desc_order_dst", out_dst, port_idx_t'(i));
            chk("desc_order_last", out_last, 1);
            idle(1, 1);
        end
        chk("desc_empty", out_valid, 0);

        // Reset during beat 2 of a 5-beat packet with buffered data and a nonzero drop count.
        cyc(0, 8'h00, 0, 2'd0, 0, 0, 1);
        send_pkt(2, 8'h70, 2'd2, 1, 0);
        send_pkt(2, 8'h90, 2'd3, 0, 0);
        cyc(1, 8'hE0, 0, 2'd1, 0, 0, 0);
        cyc(1, 8'hE1, 0, 2'd1, 0, 0, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_dst", out_dst, 0);
        chk("mid_rst_drop", drop_count, 0);
        send_pkt(3, 8'hD0, 2'd2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_data", out_data, 8'hD0 + 8'(i));
            chk("post_rst_dst", out_dst, 2'd2);
            idle(1, 1);
        end
        chk("post_rst_done", out_valid, 0);

        // Random traffic against the model.
        cyc(0, 8'h00, 0, 2'd0, 0, 0, 1);
        for (int p = 0; p < 200; p++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 80) : $urandom_range(1, 12);
            send_pkt(len, 8'($urandom), port_idx_t'($urandom), (len > 1) && ($urandom_range(0, 4) == 0), 2);
            idle($urandom_range(0, 2), 2);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ingress_packet_buffer.md
Name: ingress_packet_buffer

Overview:
- Per-ingress-port store-and-forward packet buffer that sits directly upstream of the per-egress round-robin scheduler.
- Accepts stream beats from the packet filter and holds them until the whole packet is stored.
- Then presents the packet as a contiguous valid burst with its destination index.
- Discards packets that overflow the buffer or that the filter rejects, so a partial packet is never visible downstream.

Parameters:
- DATA_WIDTH, 8, payload width of one beat.
- DEPTH, 64, data FIFO depth in beats; power of 2.
- MAX_PKTS, 8, descriptor FIFO depth, i.e. the maximum number of complete packets held; power of 2.
- N_PORTS, 4, number of switch ports.
- IDX_WIDTH, 2, log2(N_PORTS); width of the destination index.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  beat payload from the filter.
- in_valid  in  1  beat valid.
- in_last  in  1  last beat of packet.
- in_dst  in  IDX_WIDTH  destination port; sampled on the first beat only.
- in_drop  in  1  filter reject; qualified only with in_valid && in_last.
- in_ready  out  1  accept; 1 in every cycle after reset.
- out_data  out  DATA_WIDTH  head beat payload.
- out_valid  out  1  a complete packet is buffered.
- out_last  out  1  head beat is last of its packet.
- out_dst  out  IDX_WIDTH  destination of the head packet.
- out_ready  in  1  ingress_ready from the scheduler.
- drop_count  out  16  saturating count of discarded packets.

Behaviour:
- Reset (synchronous, active-high, clk edge) clears all pointers, counts and the FSM, regardless of any in-flight packet:
  - in_ready=0, out_valid=0, out_last=0, out_data=0, out_dst=0, drop_count=0.
  - Any partial packet is lost and not counted.
- Storage:
  - Data FIFO is DEPTH x (DATA_WIDTH+1); bit DATA_WIDTH holds the last flag.
  - Pointers are log2(DEPTH)+1 bits: wr_ptr (speculative), commit_ptr, rd_ptr. Arithmetic is modulo 2^(log2(DEPTH)+1); the low bits address memory.
  - used = wr_ptr - rd_ptr; full when used == DEPTH.
- Input FSM states: IDLE, RECV, DISCARD. A beat is accepted when in_valid && in_ready.
  - IDLE, first beat, descriptor FIFO not full and data not full: write the beat, latch in_dst.
    - If in_last is also set: commit now, or roll back if in_drop (single-beat packet). Stay in IDLE.
    - Otherwise go to RECV.
  - IDLE, first beat, descriptor FIFO full or data full:
    - If in_last is also set: increment drop_count, stay in IDLE.
    - Otherwise go to DISCARD.
  - RECV, beat with data not full: write the beat.
    - If in_last && !in_drop: commit_ptr <= wr_ptr+1, push the latched dst into the descriptor FIFO, go to IDLE.
    - If in_last && in_drop: wr_ptr <= commit_ptr, drop_count++, go to IDLE.
  - RECV, beat with data full: wr_ptr <= commit_ptr.
    - If in_last: drop_count++, go to IDLE.
    - Otherwise go to DISCARD.
  - DISCARD: beats are accepted and not stored. On in_last: wr_ptr <= commit_ptr, drop_count++, go to IDLE.
- drop_count saturates at 16'hFFFF.
- Output:
  - out_valid = descriptor count != 0.
  - out_data and out_last are read combinationally from mem[rd_ptr].
  - out_dst = descriptor head.
  - Zero-cycle latency from commit to out_valid visibility on the next cycle, i.e. a committed packet is visible one cycle after its last beat is accepted.
  - Transfer when out_valid && out_ready: rd_ptr++. If out_last, pop the descriptor.
  - out_valid stays 1 for every beat of a packet; it never drops mid-packet.
- Simultaneous events:
  - Descriptor push and pop in the same cycle leave the count unchanged.
  - A read frees space in the same cycle it is evaluated only for the next cycle's full check; full is computed from registered pointers.
- A packet longer than DEPTH beats is always dropped.
- out_ready while out_valid=0 has no effect.

Decomposition:
- pkt_switch_pkg holds N_PORTS, IDX_WIDTH, DATA_WIDTH and the typedef port_idx_t.
- The FSM typedef in_state_t {IDLE, RECV, DISCARD} is local to this module.
- Sub-module sync_fifo (parameterised WIDTH, DEPTH; push/pop/full/empty/count) implements the descriptor FIFO.
- The data FIFO is local because it needs rollback.

Test Plan:
- 3-beat packet 0x11, 0x22, 0x33 with in_dst=2, out_ready=1:
  - out_valid rises 1 cycle after the last beat is accepted.
  - Outputs 0x11, 0x22, 0x33 with out_dst=2, out_last only on 0x33.
  - out_valid falls afterwards.
- Single-beat packet 0xA5 with in_dst=1:
  - Exactly one output beat with out_last=1 and out_dst=1.
- 4-beat packet with in_drop=1 on the last beat:
  - out_valid stays 0 and drop_count=1.
  - A following 2-beat packet is output intact.
- DEPTH=64, out_ready=0, send a 60-beat packet and then a 10-beat packet:
  - First packet is buffered.
  - Second packet is dropped (drop_count=1).
  - After draining, a 4-beat packet is accepted.
- Send MAX_PKTS+1 one-beat packets with out_ready=0:
  - 8 are buffered; the 9th is dropped.
  - Drain order and dst values match the send order.
- Assert reset for 1 cycle during beat 2 of a 5-beat packet:
  - All outputs and drop_count read 0.
  - The next packet passes unaltered.
